// File: rtl/qs_pkg.sv
// ---------------------------------------------------------------------------
// qs_pkg
// Shared types for the qs sort engine and its output-stream checker.
//   QS_W          : default data beat width (w_t)
//   QS_LEN_W      : default packet length counter width
//   out_chk_state_t : qs_out_chk FSM state (IDLE, ACTIVE)
//   out_chk_rpt_t   : packed packet report {len, ok, ord, frm, qs, ovf, csum}
// The report struct is sized to the defaults; narrower instances of the
// checker zero-extend into it.
// ---------------------------------------------------------------------------
package qs_pkg;

    localparam int QS_W     = 32;
    localparam int QS_LEN_W = 16;

    typedef logic [QS_W-1:0] w_t;

    typedef enum logic [0:0] {
        OUT_CHK_IDLE   = 1'b0,
        OUT_CHK_ACTIVE = 1'b1
    } out_chk_state_t;

    typedef struct packed {
        logic [QS_LEN_W-1:0] len;
        logic                ok;
        logic                ord;
        logic                frm;
        logic                qs;
        logic                ovf;
        logic [QS_W-1:0]     csum;
    } out_chk_rpt_t;

endpackage

// File: rtl/qs_out_chk.sv
// ---------------------------------------------------------------------------
// qs_out_chk
// Receiver/checker for the qs sorted-output beat stream (no backpressure).
// Per packet it checks framing, non-decreasing order and engine error flags,
// counts length (saturating) and issues a registered one-cycle report.
//
// Parameters:
//   W      : data beat width (<= qs_pkg::QS_W)
//   LEN_W  : length counter width (<= qs_pkg::QS_LEN_W)
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   in_vld/sop/eop/err/dat   : input beat stream
//   rpt_vld_r                : one-cycle report strobe
//   rpt_len_r                : beats in packet (saturating)
//   rpt_ok_r                 : packet passed all checks
//   rpt_err_ord_r/frm_r/qs_r : order / framing / engine error seen
//   rpt_ovf_r                : length counter saturated
//   rpt_csum_r               : sum of packet data mod 2^W
//   pkt_cnt_r, bad_cnt_r     : running report / failed-report counters
//
// Build option QS_OUT_CHK_CSUM_EN: when defined the checksum accumulator is
// built; otherwise rpt_csum_r is tied to 0.
// ---------------------------------------------------------------------------
module qs_out_chk
    import qs_pkg::*;
#(
    parameter int W     = QS_W,
    parameter int LEN_W = QS_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic             in_err,
    input  logic [W-1:0]     in_dat,
    output logic             rpt_vld_r,
    output logic [LEN_W-1:0] rpt_len_r,
    output logic             rpt_ok_r,
    output logic             rpt_err_ord_r,
    output logic             rpt_err_frm_r,
    output logic             rpt_err_qs_r,
    output logic             rpt_ovf_r,
    output logic [W-1:0]     rpt_csum_r,
    output logic [31:0]      pkt_cnt_r,
    output logic [31:0]      bad_cnt_r
);

    if (W > QS_W || LEN_W > QS_LEN_W) begin : g_bad_param
        $error("qs_out_chk: W/LEN_W exceed the qs_pkg report field widths");
    end

`ifdef QS_OUT_CHK_CSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Packet state. A framing error is only ever discovered at the moment a
    // packet is closed, so it never needs to live in a sticky register.
    // -----------------------------------------------------------------------
    out_chk_state_t   state_q, state_d;
    logic [W-1:0]     prev_q, prev_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ord_q, ord_d;
    logic             qs_q, qs_d;
    logic             ovf_q, ovf_d;
    logic [W-1:0]     sum_cur;

`ifdef QS_OUT_CHK_CSUM_EN
    logic [W-1:0]     sum_q, sum_d;
    assign sum_cur = sum_q;
`else
    assign sum_cur = '0;
`endif

    // Report path: up to two reports can be produced in one cycle (sop
    // arriving mid-packet with eop). The second waits in hold_q.
    out_chk_rpt_t     new_a, new_b;
    logic             new_a_vld, new_b_vld;
    logic [W-1:0]     acc;

    out_chk_rpt_t     hold_q, hold_d;
    logic             hold_vld_q, hold_vld_d;
    out_chk_rpt_t     rpt_q, rpt_d;
    logic             rpt_vld_q, rpt_vld_d;
    logic [31:0]      pkt_cnt_q, pkt_cnt_d;
    logic [31:0]      bad_cnt_q, bad_cnt_d;
    logic             emit;
    out_chk_rpt_t     emit_rpt;

    function automatic out_chk_rpt_t mk_rpt(
        input logic [LEN_W-1:0] len,
        input logic             ord,
        input logic             frm,
        input logic             qs,
        input logic             ovf,
        input logic [W-1:0]     csum
    );
        out_chk_rpt_t r;
        r      = '0;
        r.len  = QS_LEN_W'(len);
        r.ord  = ord;
        r.frm  = frm;
        r.qs   = qs;
        r.ovf  = ovf;
        r.ok   = ~(ord | frm | qs | ovf);
        r.csum = CSUM_EN ? QS_W'(csum) : '0;
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // Beat processing / FSM
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        len_d     = len_q;
        ord_d     = ord_q;
        qs_d      = qs_q;
        ovf_d     = ovf_q;
        acc       = '0;
        new_a     = '0;
        new_a_vld = 1'b0;
        new_b     = '0;
        new_b_vld = 1'b0;
`ifdef QS_OUT_CHK_CSUM_EN
        sum_d     = sum_q;
`endif
        if (in_vld) begin
            if (in_sop) begin
                // sop while a packet is open: close it as a framing error.
                if (state_q == OUT_CHK_ACTIVE) begin
                    new_a     = mk_rpt(len_q, ord_q, 1'b1, qs_q, ovf_q, sum_cur);
                    new_a_vld = 1'b1;
                end
                prev_d = in_dat;
                len_d  = LEN_W'(1);
                ord_d  = 1'b0;
                qs_d   = in_err;
                ovf_d  = 1'b0;
`ifdef QS_OUT_CHK_CSUM_EN
                sum_d  = in_dat;
`endif
                if (in_eop) begin
                    state_d = OUT_CHK_IDLE;
                    if (state_q == OUT_CHK_ACTIVE) begin
                        new_b     = mk_rpt(LEN_W'(1), 1'b0, 1'b0, in_err, 1'b0, in_dat);
                        new_b_vld = 1'b1;
                    end else begin
                        new_a     = mk_rpt(LEN_W'(1), 1'b0, 1'b0, in_err, 1'b0, in_dat);
                        new_a_vld = 1'b1;
                    end
                end else begin
                    state_d = OUT_CHK_ACTIVE;
                end
            end else if (state_q == OUT_CHK_IDLE) begin
                // Orphan beat: reported as its own one-beat framing error.
                new_a     = mk_rpt(LEN_W'(1), 1'b0, 1'b1, in_err, 1'b0, in_dat);
                new_a_vld = 1'b1;
            end else begin
                ord_d  = ord_q | (in_dat < prev_q);
                prev_d = in_dat;
                if (&len_q) begin
                    ovf_d = 1'b1;
                end else begin
                    len_d = len_q + LEN_W'(1);
                end
                qs_d = qs_q | in_err;
                acc  = sum_cur + in_dat;
`ifdef QS_OUT_CHK_CSUM_EN
                sum_d = acc;
`endif
                if (in_eop) begin
                    new_a     = mk_rpt(len_d, ord_d, 1'b0, qs_d, ovf_d, acc);
                    new_a_vld = 1'b1;
                    state_d   = OUT_CHK_IDLE;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Report ordering. A held report always goes out first. While a report
    // is held the FSM is necessarily IDLE (the double-report case ends in
    // IDLE), so at most one new report can arrive and it takes the hold slot.
    // -----------------------------------------------------------------------
    always_comb begin
        emit     = hold_vld_q | new_a_vld;
        emit_rpt = hold_vld_q ? hold_q : new_a;
        if (hold_vld_q) begin
            hold_vld_d = new_a_vld;
            hold_d     = new_a_vld ? new_a : hold_q;
        end else begin
            hold_vld_d = new_b_vld;
            hold_d     = new_b_vld ? new_b : hold_q;
        end
        rpt_vld_d = emit;
        rpt_d     = emit ? emit_rpt : rpt_q;
        pkt_cnt_d = pkt_cnt_q + {31'd0, emit};
        bad_cnt_d = bad_cnt_q + {31'd0, emit & ~emit_rpt.ok};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= OUT_CHK_IDLE;
            prev_q     <= '0;
            len_q      <= '0;
            ord_q      <= 1'b0;
            qs_q       <= 1'b0;
            ovf_q      <= 1'b0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            rpt_q      <= '0;
            rpt_vld_q  <= 1'b0;
            pkt_cnt_q  <= '0;
            bad_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            len_q      <= len_d;
            ord_q      <= ord_d;
            qs_q       <= qs_d;
            ovf_q      <= ovf_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            rpt_q      <= rpt_d;
            rpt_vld_q  <= rpt_vld_d;
            pkt_cnt_q  <= pkt_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
        end
    end

`ifdef QS_OUT_CHK_CSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    // Narrow instances leave the upper struct bits at zero.
    if (LEN_W < QS_LEN_W) begin : g_len_pad
        logic unused_len;
        assign unused_len = ^rpt_q.len[QS_LEN_W-1:LEN_W];
    end
    if (W < QS_W) begin : g_dat_pad
        logic unused_csum;
        assign unused_csum = ^rpt_q.csum[QS_W-1:W];
    end

    assign rpt_vld_r     = rpt_vld_q;
    assign rpt_len_r     = rpt_q.len[LEN_W-1:0];
    assign rpt_ok_r      = rpt_q.ok;
    assign rpt_err_ord_r = rpt_q.ord;
    assign rpt_err_frm_r = rpt_q.frm;
    assign rpt_err_qs_r  = rpt_q.qs;
    assign rpt_ovf_r     = rpt_q.ovf;
    assign rpt_csum_r    = rpt_q.csum[W-1:0];
    assign pkt_cnt_r     = pkt_cnt_q;
    assign bad_cnt_r     = bad_cnt_q;

endmodule

// File: tb/tb_qs_out_chk.sv
// ---------------------------------------------------------------------------
// tb_qs_out_chk
// Drives one beat stream into two checkers (LEN_W=16 and LEN_W=4) and
// compares every output each cycle against a packet-level reference model:
// open-packet beats are kept in a queue and reports are derived from the
// whole beat list when the packet closes; reports leave one per cycle.
// ---------------------------------------------------------------------------
module tb_qs_out_chk;

`ifdef QS_OUT_CHK_CSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_vld = 1'b0, in_sop = 1'b0, in_eop = 1'b0, in_err = 1'b0;
    logic [31:0] in_dat = '0;

    logic        a_vld, a_ok, a_ord, a_frm, a_qs, a_ovf;
    logic [15:0] a_len;
    logic [31:0] a_csum, a_pkt, a_bad;
    logic        b_vld, b_ok, b_ord, b_frm, b_qs, b_ovf;
    logic [3:0]  b_len;
    logic [31:0] b_csum, b_pkt, b_bad;

    always #5 clk = ~clk;

    qs_out_chk #(.W(32), .LEN_W(16)) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_sop(in_sop), .in_eop(in_eop),
        .in_err(in_err), .in_dat(in_dat), .rpt_vld_r(a_vld), .rpt_len_r(a_len),
        .rpt_ok_r(a_ok), .rpt_err_ord_r(a_ord), .rpt_err_frm_r(a_frm),
        .rpt_err_qs_r(a_qs), .rpt_ovf_r(a_ovf), .rpt_csum_r(a_csum),
        .pkt_cnt_r(a_pkt), .bad_cnt_r(a_bad)
    );

    qs_out_chk #(.W(32), .LEN_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_sop(in_sop), .in_eop(in_eop),
        .in_err(in_err), .in_dat(in_dat), .rpt_vld_r(b_vld), .rpt_len_r(b_len),
        .rpt_ok_r(b_ok), .rpt_err_ord_r(b_ord), .rpt_err_frm_r(b_frm),
        .rpt_err_qs_r(b_qs), .rpt_ovf_r(b_ovf), .rpt_csum_r(b_csum),
        .pkt_cnt_r(b_pkt), .bad_cnt_r(b_bad)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          cnt;
        bit          ord;
        bit          frm;
        bit          qs;
        logic [31:0] csum;
    } mrep_t;

    mrep_t       rq[$];
    logic [31:0] m_beats[$];
    bit          m_err;
    bit          m_open;

    logic        e_vld, e_ord, e_frm, e_qs;
    logic [31:0] e_csum, e_pkt, e_bad16, e_bad4;
    logic [15:0] e_len16;
    logic [3:0]  e_len4;
    logic        e_ovf16, e_ovf4, e_ok16, e_ok4;

    function automatic mrep_t close_pkt(input bit frm);
        mrep_t r;
        r.cnt  = m_beats.size();
        r.ord  = 1'b0;
        r.csum = '0;
        for (int i = 0; i < m_beats.size(); i++) begin
            r.csum = r.csum + m_beats[i];
            if (i > 0 && m_beats[i] < m_beats[i-1]) r.ord = 1'b1;
        end
        r.frm = frm;
        r.qs  = m_err;
        return r;
    endfunction

    task automatic model_reset();
        rq.delete();
        m_beats.delete();
        m_err  = 0;
        m_open = 0;
        {e_vld, e_ord, e_frm, e_qs, e_ovf16, e_ovf4, e_ok16, e_ok4} = '0;
        e_csum = '0; e_pkt = '0; e_bad16 = '0; e_bad4 = '0;
        e_len16 = '0; e_len4 = '0;
    endtask

    task automatic model_step(input bit v, input bit s, input bit e, input bit er,
                              input logic [31:0] d);
        mrep_t r;
        if (v) begin
            if (s) begin
                if (m_open) rq.push_back(close_pkt(1'b1));
                m_beats.delete();
                m_beats.push_back(d);
                m_err  = er;
                m_open = 1;
                if (e) begin
                    rq.push_back(close_pkt(1'b0));
                    m_open = 0;
                end
            end else if (!m_open) begin
                r.cnt = 1; r.ord = 0; r.frm = 1; r.qs = er; r.csum = d;
                rq.push_back(r);
            end else begin
                m_beats.push_back(d);
                m_err = m_err | er;
                if (e) begin
                    rq.push_back(close_pkt(1'b0));
                    m_open = 0;
                end
            end
        end
        if (rq.size() > 0) begin
            r       = rq.pop_front();
            e_vld   = 1'b1;
            e_ord   = r.ord;
            e_frm   = r.frm;
            e_qs    = r.qs;
            e_csum  = CSUM_EN ? r.csum : 32'd0;
            e_len16 = (r.cnt > 65535) ? 16'hFFFF : 16'(r.cnt);
            e_ovf16 = (r.cnt > 65535);
            e_len4  = (r.cnt > 15) ? 4'hF : 4'(r.cnt);
            e_ovf4  = (r.cnt > 15);
            e_ok16  = !(r.ord || r.frm || r.qs || e_ovf16);
            e_ok4   = !(r.ord || r.frm || r.qs || e_ovf4);
            e_pkt   = e_pkt + 1;
            if (!e_ok16) e_bad16 = e_bad16 + 1;
            if (!e_ok4)  e_bad4  = e_bad4 + 1;
        end else begin
            e_vld = 1'b0;
        end
    endtask

    task automatic check_all();
        chk("vld",     64'(a_vld),  64'(e_vld));
        chk("len",     64'(a_len),  64'(e_len16));
        chk("ok",      64'(a_ok),   64'(e_ok16));
        chk("ord",     64'(a_ord),  64'(e_ord));
        chk("frm",     64'(a_frm),  64'(e_frm));
        chk("qs",      64'(a_qs),   64'(e_qs));
        chk("ovf",     64'(a_ovf),  64'(e_ovf16));
        chk("csum",    64'(a_csum), 64'(e_csum));
        chk("pkt_cnt", 64'(a_pkt),  64'(e_pkt));
        chk("bad_cnt", 64'(a_bad),  64'(e_bad16));
        chk("vld4",    64'(b_vld),  64'(e_vld));
        chk("len4",    64'(b_len),  64'(e_len4));
        chk("ok4",     64'(b_ok),   64'(e_ok4));
        chk("ord4",    64'(b_ord),  64'(e_ord));
        chk("frm4",    64'(b_frm),  64'(e_frm));
        chk("ovf4",    64'(b_ovf),  64'(e_ovf4));
        chk("csum4",   64'(b_csum), 64'(e_csum));
        chk("pkt4",    64'(b_pkt),  64'(e_pkt));
        chk("bad4",    64'(b_bad),  64'(e_bad4));
    endtask

    // One clock: check the outputs of the previous edge, then present a beat.
    task automatic cyc(input bit v, input bit s, input bit e, input bit er,
                       input logic [31:0] d);
        @(negedge clk);
        check_all();
        in_vld = v; in_sop = s; in_eop = e; in_err = er; in_dat = d;
        model_step(v, s, e, er, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        check_all();
        rst = 1'b1;
        in_vld = 0; in_sop = 0; in_eop = 0; in_err = 0; in_dat = '0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_all();
        end
        rst = 1'b0;
        model_step(0, 0, 0, 0, 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        model_reset();
        do_reset();

        // Sorted 4-beat packet.
        cyc(1, 1, 0, 0, 3); cyc(1, 0, 0, 0, 5); cyc(1, 0, 0, 0, 5); cyc(1, 0, 1, 0, 9);
        idle(1);
        chk("tp_len",  64'(a_len),  64'd4);
        chk("tp_csum", 64'(a_csum), CSUM_EN ? 64'd22 : 64'd0);
        chk("tp_pkt",  64'(a_pkt),  64'd1);

        // Order violation.
        cyc(1, 1, 0, 0, 8); cyc(1, 0, 0, 0, 2); cyc(1, 0, 1, 0, 4);
        idle(1);
        chk("tp_ord",  64'(a_ord), 64'd1);
        chk("tp_bad",  64'(a_bad), 64'd1);

        // Orphan, then sop with sop|eop behind it (two consecutive reports).
        cyc(1, 0, 0, 0, 7);
        idle(1);
        cyc(1, 1, 0, 0, 1); cyc(1, 1, 1, 0, 2);
        idle(3);

        // Engine error in the middle beat.
        cyc(1, 1, 0, 0, 1); cyc(1, 0, 0, 1, 2); cyc(1, 0, 1, 0, 3);
        idle(1);

        // Saturation boundaries on the narrow instance: 15, 16 and 17 beats.
        for (int n = 15; n <= 17; n++) begin
            for (int i = 0; i < n; i++) cyc(1, i == 0, i == n - 1, 0, 32'(i));
            idle(1);
        end
        chk("tp_len4", 64'(b_len), 64'd15);
        chk("tp_ovf4", 64'(b_ovf), 64'd1);

        // Reset mid-packet discards it.
        cyc(1, 1, 0, 0, 1); cyc(1, 0, 0, 0, 2);
        do_reset();
        cyc(1, 1, 1, 0, 0);
        idle(1);
        chk("tp_rst_pkt", 64'(a_pkt), 64'd1);
        chk("tp_rst_ok",  64'(a_ok),  64'd1);

        // Back-to-back single-beat packets, then again right after a double.
        for (int i = 0; i < 5; i++) cyc(1, 1, 1, 0, 32'(i));
        cyc(1, 1, 0, 0, 4); cyc(1, 1, 1, 0, 5);
        for (int i = 0; i < 4; i++) cyc(1, 1, 1, 0, 32'(i));
        cyc(1, 0, 0, 0, 9);
        idle(3);

        // Randomized stream.
        d = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) d = $urandom();
            else d = d + $urandom_range(0, 3) - (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, d);
            if (i == 1500) do_reset();
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
